// File: rtl/date_set_ctrl.sv
// Set-mode controller for the BCD calendar chain: freezes the counters while a
// shadow date is edited field by field, then commits it with a one-cycle LOAD.
module date_set_ctrl #(
    parameter int REPEAT_DLY = 50,
    parameter int REPEAT_PER = 10,
    parameter int TIMEOUT    = 3000,
    parameter int BLINK_HALF = 25
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       TICK,
    input  logic       BTN_MODE,
    input  logic       BTN_UP,
    input  logic [7:0] YEAR_cur,
    input  logic [7:0] MONTH_cur,
    input  logic [7:0] DAY_cur,
    output logic       ENABLE,
    output logic       LOAD,
    output logic [7:0] YEAR_set,
    output logic [7:0] MONTH_set,
    output logic [7:0] DAY_set,
    output logic       is_leap,
    output logic [1:0] SEL,
    output logic       BLINK
);
    typedef enum logic [2:0] {
        ST_RUN    = 3'd0,
        ST_SET_Y  = 3'd1,
        ST_SET_M  = 3'd2,
        ST_SET_D  = 3'd3,
        ST_COMMIT = 3'd4
    } state_t;

    localparam int RW = $clog2(REPEAT_DLY + REPEAT_PER + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int BW = $clog2(BLINK_HALF + 1);
    localparam logic [RW-1:0] DLY_LAST = RW'(REPEAT_DLY - 1);
    localparam logic [RW-1:0] PER_LAST = RW'(REPEAT_PER - 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);
    localparam logic [BW-1:0] BH_LAST  = BW'(BLINK_HALF - 1);

    function automatic logic [7:0] bcd_inc_f(input logic [7:0] v);
        logic [7:0] r;
        if (v[3:0] >= 4'd9) begin
            r[3:0] = 4'd0;
            r[7:4] = (v[7:4] >= 4'd9) ? 4'd0 : v[7:4] + 4'd1;
        end else begin
            r[7:4] = v[7:4];
            r[3:0] = v[3:0] + 4'd1;
        end
        return r;
    endfunction

    // Century 2000..2099: leap years are exactly the multiples of four.
    function automatic logic leap_f(input logic [7:0] y);
        logic r;
        if (!y[4]) begin
            r = (y[3:0] == 4'd0) || (y[3:0] == 4'd4) || (y[3:0] == 4'd8);
        end else begin
            r = (y[3:0] == 4'd2) || (y[3:0] == 4'd6);
        end
        return r;
    endfunction

    function automatic logic [7:0] max_day_f(input logic [7:0] m, input logic lp);
        logic [7:0] r;
        case (m)
            8'h02:                      r = lp ? 8'h29 : 8'h28;
            8'h04, 8'h06, 8'h09, 8'h11: r = 8'h30;
            default:                    r = 8'h31;
        endcase
        return r;
    endfunction

    state_t      r_state, w_state_nxt;
    logic        r_mode_s1, r_mode_s2, r_mode_d, r_up_s1, r_up_s2, r_up_d;
    logic [7:0]  r_year, r_month, r_day, w_year_nxt, w_month_nxt, w_day_nxt, w_day_max;
    logic        r_enable, r_load, r_leap, r_blink, r_rep_armed;
    logic [1:0]  r_sel, w_sel_nxt;
    logic [RW-1:0] r_rep_cnt;
    logic [TW-1:0] r_idle_cnt;
    logic [BW-1:0] r_blink_cnt;
    logic        w_mode_p, w_up_raw, w_up_p, w_in_set, w_nxt_set;
    logic        w_rep_fire, w_timeout, w_inc, w_chg;

    assign w_mode_p   = r_mode_s2 & ~r_mode_d;
    assign w_up_raw   = r_up_s2 & ~r_up_d;
    assign w_up_p     = w_up_raw & ~w_mode_p;
    assign w_in_set   = (r_state == ST_SET_Y) || (r_state == ST_SET_M) || (r_state == ST_SET_D);
    assign w_nxt_set  = (w_state_nxt == ST_SET_Y) || (w_state_nxt == ST_SET_M) ||
                        (w_state_nxt == ST_SET_D);
    assign w_chg      = (w_state_nxt != r_state);
    assign w_day_max  = max_day_f(r_month, leap_f(r_year));
    assign w_rep_fire = w_in_set & r_up_s2 & TICK &
                        (r_rep_armed ? (r_rep_cnt == PER_LAST) : (r_rep_cnt == DLY_LAST));
    // A button edge in the same cycle restarts the idle window instead of expiring it.
    assign w_timeout  = w_in_set & TICK & ~w_mode_p & ~w_up_raw & (r_idle_cnt == TO_LAST);

    // Button synchronisers and edge-detect history.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            {r_mode_s1, r_mode_s2, r_mode_d} <= 3'b000;
            {r_up_s1, r_up_s2, r_up_d}       <= 3'b000;
        end else begin
            r_mode_s1 <= BTN_MODE;
            r_mode_s2 <= r_mode_s1;
            r_mode_d  <= r_mode_s2;
            r_up_s1   <= BTN_UP;
            r_up_s2   <= r_up_s1;
            r_up_d    <= r_up_s2;
        end
    end

    // Next state and next shadow values; MODE beats timeout beats increment.
    always_comb begin
        w_state_nxt = r_state;
        w_year_nxt  = r_year;
        w_month_nxt = r_month;
        w_day_nxt   = r_day;
        w_inc       = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (w_mode_p) begin
                    w_state_nxt = ST_SET_Y;
                    w_year_nxt  = YEAR_cur;
                    w_month_nxt = MONTH_cur;
                    w_day_nxt   = DAY_cur;
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_SET_Y: begin
                if (w_mode_p) begin
                    w_state_nxt = ST_SET_M;
                end else if (w_timeout) begin
                    w_state_nxt = ST_RUN;
                end else if (w_up_p || w_rep_fire) begin
                    w_inc      = 1'b1;
                    w_year_nxt = bcd_inc_f(r_year);
                end else begin
                    w_state_nxt = ST_SET_Y;
                end
            end
            ST_SET_M: begin
                if (w_mode_p) begin
                    w_state_nxt = ST_SET_D;
                    w_day_nxt   = (r_day > w_day_max) ? w_day_max : r_day;
                end else if (w_timeout) begin
                    w_state_nxt = ST_RUN;
                end else if (w_up_p || w_rep_fire) begin
                    w_inc       = 1'b1;
                    w_month_nxt = (r_month >= 8'h12) ? 8'h01 : bcd_inc_f(r_month);
                end else begin
                    w_state_nxt = ST_SET_M;
                end
            end
            ST_SET_D: begin
                if (w_mode_p) begin
                    w_state_nxt = ST_COMMIT;
                end else if (w_timeout) begin
                    w_state_nxt = ST_RUN;
                end else if (w_up_p || w_rep_fire) begin
                    w_inc     = 1'b1;
                    w_day_nxt = (r_day >= w_day_max) ? 8'h01 : bcd_inc_f(r_day);
                end else begin
                    w_state_nxt = ST_SET_D;
                end
            end
            ST_COMMIT: w_state_nxt = ST_RUN;
            default:   w_state_nxt = ST_RUN;
        endcase
        case (w_state_nxt)
            ST_SET_Y: w_sel_nxt = 2'd1;
            ST_SET_M: w_sel_nxt = 2'd2;
            ST_SET_D: w_sel_nxt = 2'd3;
            default:  w_sel_nxt = 2'd0;
        endcase
    end

    // State, shadow registers and registered outputs.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            r_state  <= ST_RUN;
            r_year   <= 8'h00;
            r_month  <= 8'h01;
            r_day    <= 8'h01;
            r_enable <= 1'b0;
            r_load   <= 1'b0;
            r_sel    <= 2'd0;
            r_leap   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_year   <= w_year_nxt;
            r_month  <= w_month_nxt;
            r_day    <= w_day_nxt;
            r_enable <= (w_state_nxt == ST_RUN);
            r_load   <= (w_state_nxt == ST_COMMIT);
            r_sel    <= w_sel_nxt;
            r_leap   <= leap_f((w_state_nxt == ST_RUN) ? YEAR_cur : w_year_nxt);
        end
    end

    // Auto-repeat, idle and blink tick counters.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            r_rep_cnt   <= '0;
            r_rep_armed <= 1'b0;
            r_idle_cnt  <= '0;
            r_blink_cnt <= '0;
            r_blink     <= 1'b0;
        end else begin
            if (w_chg || !w_in_set || !r_up_s2) begin
                r_rep_cnt   <= '0;
                r_rep_armed <= 1'b0;
            end else if (w_rep_fire) begin
                r_rep_cnt   <= '0;
                r_rep_armed <= 1'b1;
            end else if (TICK) begin
                r_rep_cnt <= r_rep_cnt + RW'(1);
            end
            if (w_chg || !w_in_set || w_mode_p || w_up_raw) begin
                r_idle_cnt <= '0;
            end else if (TICK) begin
                r_idle_cnt <= r_idle_cnt + TW'(1);
            end
            if (w_chg || w_inc || !w_nxt_set) begin
                r_blink_cnt <= '0;
                r_blink     <= 1'b0;
            end else if (TICK) begin
                if (r_blink_cnt == BH_LAST) begin
                    r_blink_cnt <= '0;
                    r_blink     <= ~r_blink;
                end else begin
                    r_blink_cnt <= r_blink_cnt + BW'(1);
                end
            end
        end
    end

    assign ENABLE    = r_enable;
    assign LOAD      = r_load;
    assign YEAR_set  = r_year;
    assign MONTH_set = r_month;
    assign DAY_set   = r_day;
    assign is_leap   = r_leap;
    assign SEL       = r_sel;
    assign BLINK     = r_blink;
endmodule

// File: tb/tb_date_set_ctrl.sv
// Directed bench for date_set_ctrl: a decimal-arithmetic model of the edit
// session is compared with the DUT every cycle, plus hand-computed spot checks.
module tb_date_set_ctrl;
    logic       CLK = 1'b0;
    logic       RESET, TICK, BTN_MODE, BTN_UP;
    logic [7:0] YEAR_cur, MONTH_cur, DAY_cur;
    logic       ENABLE, LOAD, is_leap, BLINK;
    logic [7:0] YEAR_set, MONTH_set, DAY_set;
    logic [1:0] SEL;

    always #5 CLK = ~CLK;

    date_set_ctrl dut (
        .CLK(CLK), .RESET(RESET), .TICK(TICK), .BTN_MODE(BTN_MODE), .BTN_UP(BTN_UP),
        .YEAR_cur(YEAR_cur), .MONTH_cur(MONTH_cur), .DAY_cur(DAY_cur),
        .ENABLE(ENABLE), .LOAD(LOAD), .YEAR_set(YEAR_set), .MONTH_set(MONTH_set),
        .DAY_set(DAY_set), .is_leap(is_leap), .SEL(SEL), .BLINK(BLINK)
    );

    int n_tests = 0, n_fail = 0, load_cnt = 0, load_saved = 0;
    bit chk_en = 1'b0, e_rst = 1'b1, e_held = 1'b0;
    // Model: 0 run, 1 year, 2 month, 3 day, 4 commit; dates held as plain integers.
    int e_state = 0, e_y = 0, e_m = 1, e_d = 1;
    int e_bcnt = 0, e_idle = 0, e_rep = 0;
    int c_y = 23, c_m = 5, c_d = 17;
    logic [29:0] act_v, exp_v;
    bit exp_en, exp_load, exp_blink, exp_leap, set_st;
    logic [1:0] exp_sel;

    function automatic logic [7:0] to_bcd(input int n);
        logic [3:0] t, o;
        t = 4'(n / 10);
        o = 4'(n % 10);
        return {t, o};
    endfunction

    function automatic bit leap_y(input int y);
        return ((2000 + y) % 4) == 0;
    endfunction

    function automatic int mdays(input int m, input int y);
        int r;
        case (m)
            2:             r = leap_y(y) ? 29 : 28;
            4, 6, 9, 11:   r = 30;
            default:       r = 31;
        endcase
        return r;
    endfunction

    always @(negedge CLK) begin
        if (LOAD === 1'b1) load_cnt++;
        if (chk_en) begin
            set_st    = (e_state >= 1) && (e_state <= 3);
            exp_en    = (e_state == 0) && !e_rst;
            exp_load  = (e_state == 4);
            exp_sel   = set_st ? 2'(e_state) : 2'd0;
            exp_blink = set_st ? (((e_bcnt / 25) % 2) == 1) : 1'b0;
            exp_leap  = e_rst ? 1'b0 : ((e_state == 0) ? leap_y(c_y) : leap_y(e_y));
            exp_v = {exp_en, exp_load, exp_sel, exp_blink, exp_leap,
                     to_bcd(e_y), to_bcd(e_m), to_bcd(e_d)};
            act_v = {ENABLE, LOAD, SEL, BLINK, is_leap, YEAR_set, MONTH_set, DAY_set};
            n_tests++;
            if (act_v !== exp_v) begin
                n_fail++;
                $display("FAIL cycle_model t=%0t got en/ld/sel/bl/lp/ymd=%h expected %h",
                         $time, act_v, exp_v);
            end
        end
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_inc();
        case (e_state)
            1:       e_y = (e_y + 1) % 100;
            2:       e_m = (e_m == 12) ? 1 : e_m + 1;
            3:       e_d = (e_d >= mdays(e_m, e_y)) ? 1 : e_d + 1;
            default: ;
        endcase
        e_bcnt = 0;
    endtask

    task automatic model_mode();
        case (e_state)
            0: begin e_y = c_y; e_m = c_m; e_d = c_d; e_state = 1; end
            1: e_state = 2;
            2: begin
                if (e_d > mdays(e_m, e_y)) e_d = mdays(e_m, e_y);
                e_state = 3;
            end
            3: e_state = 4;
            default: ;
        endcase
        e_idle = 0;
        e_bcnt = 0;
    endtask

    task automatic model_tick();
        bit fire;
        if (e_state >= 1 && e_state <= 3) begin
            fire = 1'b0;
            if (e_held) begin
                e_rep++;
                fire = (e_rep == 50) || (e_rep > 50 && ((e_rep - 50) % 10) == 0);
            end
            e_idle++;
            if (e_idle == 3000) begin
                e_state = 0;
                e_bcnt  = 0;
            end else if (fire) begin
                model_inc();
            end else begin
                e_bcnt++;
            end
        end
    endtask

    // All tasks start and end 1 time unit after a rising edge.
    task automatic press(input bit m, input bit u);
        BTN_MODE = m;
        BTN_UP   = u;
        repeat (3) @(posedge CLK);
        #1;
        if (m) model_mode();
        else if (u && e_state >= 1 && e_state <= 3) begin model_inc(); e_idle = 0; end
        BTN_MODE = 1'b0;
        BTN_UP   = 1'b0;
        @(posedge CLK); #1;
        if (e_state == 4) e_state = 0;
        repeat (2) @(posedge CLK);
        #1;
    endtask

    task automatic do_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            TICK = 1'b1;
            @(posedge CLK); #1;
            TICK = 1'b0;
            model_tick();
            @(posedge CLK); #1;
        end
    endtask

    task automatic hold_up(input int n);
        BTN_UP = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        model_inc();
        e_idle = 0;
        e_held = 1'b1;
        e_rep  = 0;
        do_ticks(n);
        BTN_UP = 1'b0;
        e_held = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
    endtask

    task automatic set_cur(input int y, input int m, input int d);
        chk_en = 1'b0;
        c_y = y; c_m = m; c_d = d;
        YEAR_cur = to_bcd(y); MONTH_cur = to_bcd(m); DAY_cur = to_bcd(d);
        @(posedge CLK); #1;
        chk_en = 1'b1;
    endtask

    task automatic reset_mid();
        RESET = 1'b0;
        @(posedge CLK); #1;
        e_rst = 1'b1; e_state = 0; e_y = 0; e_m = 1; e_d = 1;
        e_bcnt = 0; e_idle = 0; e_held = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_year", YEAR_set, 8'h00);
        chk("rst_month", MONTH_set, 8'h01);
        chk("rst_day", DAY_set, 8'h01);
        chk("rst_sel", {6'd0, SEL}, 8'h00);
        chk("rst_enable", {7'd0, ENABLE}, 8'h00);
        RESET = 1'b1;
        @(posedge CLK); #1;
        e_rst = 1'b0;
        chk("rel_enable", {7'd0, ENABLE}, 8'h01);
    endtask

    initial begin
        RESET = 1'b0; TICK = 1'b0; BTN_MODE = 1'b0; BTN_UP = 1'b0;
        YEAR_cur = to_bcd(c_y); MONTH_cur = to_bcd(c_m); DAY_cur = to_bcd(c_d);
        repeat (3) @(posedge CLK);
        #1;
        chk_en = 1'b1;
        chk("init_enable", {7'd0, ENABLE}, 8'h00);
        chk("init_load", {7'd0, LOAD}, 8'h00);
        chk("init_year", YEAR_set, 8'h00);
        RESET = 1'b1;
        @(posedge CLK); #1;
        e_rst = 1'b0;
        chk("first_enable", {7'd0, ENABLE}, 8'h01);
        chk("first_sel", {6'd0, SEL}, 8'h00);

        press(1'b1, 1'b0);
        chk("enter_sel", {6'd0, SEL}, 8'h01);
        chk("enter_year", YEAR_set, 8'h23);
        for (int i = 0; i < 77; i++) press(1'b0, 1'b1);
        chk("year_wrap", YEAR_set, 8'h00);
        press(1'b1, 1'b0); press(1'b1, 1'b0); press(1'b1, 1'b0);
        chk("commit_loads", 8'(load_cnt), 8'd1);
        chk("commit_ymd", YEAR_set ^ MONTH_set ^ DAY_set, 8'h00 ^ 8'h05 ^ 8'h17);
        chk("commit_enable", {7'd0, ENABLE}, 8'h01);

        set_cur(23, 1, 31);
        press(1'b1, 1'b0); press(1'b1, 1'b0); press(1'b0, 1'b1); press(1'b1, 1'b0);
        chk("clamp_28", DAY_set, 8'h28);
        press(1'b1, 1'b0);
        set_cur(24, 1, 31);
        press(1'b1, 1'b0); press(1'b1, 1'b0); press(1'b0, 1'b1); press(1'b1, 1'b0);
        chk("clamp_29", DAY_set, 8'h29);
        chk("leap_24", {7'd0, is_leap}, 8'h01);
        press(1'b1, 1'b0);

        set_cur(23, 4, 30);
        press(1'b1, 1'b0); press(1'b1, 1'b0); press(1'b1, 1'b0); press(1'b0, 1'b1);
        chk("day_wrap_apr", DAY_set, 8'h01);
        press(1'b1, 1'b0);
        set_cur(23, 12, 5);
        press(1'b1, 1'b0); press(1'b1, 1'b0); press(1'b0, 1'b1);
        chk("month_wrap", MONTH_set, 8'h01);
        press(1'b1, 1'b0); press(1'b1, 1'b0);

        set_cur(10, 6, 15);
        press(1'b1, 1'b0);
        do_ticks(25);
        chk("blink_on", {7'd0, BLINK}, 8'h01);
        hold_up(95);
        chk("repeat_year", YEAR_set, 8'h16);
        do_ticks(20);
        chk("release_year", YEAR_set, 8'h16);

        press(1'b1, 1'b1);
        chk("mode_wins_sel", {6'd0, SEL}, 8'h02);
        chk("mode_wins_year", YEAR_set, 8'h16);
        press(1'b1, 1'b0);
        load_saved = load_cnt;
        do_ticks(3000);
        chk("timeout_sel", {6'd0, SEL}, 8'h00);
        chk("timeout_enable", {7'd0, ENABLE}, 8'h01);
        chk("timeout_noload", 8'(load_cnt), 8'(load_saved));
        chk("timeout_keep_day", DAY_set, 8'h15);

        set_cur(23, 5, 17);
        press(1'b1, 1'b0); press(1'b1, 1'b0);
        reset_mid();
        repeat (4) @(posedge CLK);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
